trng_vn_collector: RTL
======================

// Module: trng_vn_collector
// PURPOSE
//  Responder-side TRNG core. Samples a raw entropy bit (ring-oscillator jitter), debiases it
//  with a von Neumann extractor and assembles an N-bit word. The word is delivered over the
//  core req/res handshake (req_valid/req_ready/req_busy/res_valid/res_ready). It feeds the
//  secret input of matmlt and sha3 in the device-key flow, and runs a repetition-count health test.
// PARAMETERS
//  N          128  output word width, in debiased bits
//  DIV        4    raw sample taken every DIV clk cycles while collecting (DIV>=1)
//  RCT_LIMIT  32   consecutive identical raw samples that declare a health failure (>=2)
// PORTS
//  clk          in   1  clock
//  rst          in   1  reset, synchronous, active-high
//  raw_bit      in   1  asynchronous entropy source; 2-FF synchronised internally
//  rnd_out      out  N  random word; valid while res_valid=1
//  health_fail  out  1  repetition-count failure on the current/last request
//  req_valid    in   1  initiator requests one word
//  req_ready    out  1  core idle, will accept a request
//  req_busy     out  1  request accepted and not yet retired
//  res_valid    out  1  result available
//  res_ready    in   1  initiator consumes result
// BEHAVIOUR
//  - Reset values: req_ready=0, req_busy=0, res_valid=0, rnd_out=0, health_fail=0, state IDLE.
//    All outputs are registered. req_ready=1 from the first cycle after rst falls.
//  - States:
//    IDLE -> COLLECT when req_valid&&req_ready at edge T. At T+1: req_ready=0, req_busy=1,
//            bit count=0, sample divider=0, pair/RCT state cleared, health_fail=0.
//    COLLECT -> DONE on Nth debiased bit or on RCT failure.
//    DONE -> IDLE on res_valid&&res_ready at edge T. At T+1: res_valid=0, req_busy=0, req_ready=1.
//  - Sampling: sample strobe on the cycle divider==DIV-1. Divider wraps to 0 and runs only in COLLECT.
//    The sample is the synchroniser output.
//  - Von Neumann: consecutive samples form pairs (a,b), non-overlapping.
//    01 emits 0; 10 emits 1; 00 and 11 are discarded. Pair state restarts after every pair.
//  - Assembly: sh <= {sh[N-2:0], bit}. The first emitted bit ends in rnd_out[N-1].
//  - Completion: Nth bit shifted at edge T. At T+1: res_valid=1, rnd_out=sh.
//    Minimum latency is 2*N*DIV cycles plus 3 (sync + register).
//  - RCT: counts identical consecutive raw samples and resets to 1 on change.
//    On reaching RCT_LIMIT: next cycle state DONE, res_valid=1, health_fail=1, rnd_out=0.
//    The partial word is discarded.
//  - In DONE, rnd_out and health_fail stay stable until handshake. They hold after return to IDLE
//    and change only at the next completion.
//  - req_valid outside IDLE is ignored; there is no queuing. The initiator may hold req_valid high
//    one cycle past acceptance without causing a second request.
//  - res_ready while res_valid=0 is ignored. req_valid and res_ready may both be high in DONE;
//    only the retire takes effect, and a new request is accepted no earlier than IDLE.
//  - rst mid-COLLECT/DONE aborts: reset values at the next edge, and partial bits are lost.
// TESTING
//  1. N=8, DIV=1, synced samples 10 01 10 10 01 01 10 01 -> res_valid, rnd_out=8'hB2, health_fail=0.
//  2. Same stream with a 00 and an 11 pair interleaved -> rnd_out=8'hB2; latency +4 strobes vs 1.
//  3. Defaults, raw_bit=1 constant -> health_fail=1, rnd_out=0, res_valid by 32*4+3 cycles.
//     The next request with good entropy clears health_fail.
//  4. Hold res_ready=0 for 1000 cycles while pulsing req_valid -> rnd_out and res_valid stable,
//     req_ready=0. A 1-cycle res_ready -> req_ready=1, req_busy=0 next cycle.
//  5. req_valid high through reset, dropped one cycle after req_ready seen -> exactly one word.
//  6. rst asserted mid-COLLECT -> reset values next cycle. The next request yields a full fresh word
//     with no stale bits.

Source files
------------

// File: rtl/trng_vn_collector_if.sv
// Request/response bundle between an initiator and the TRNG collector core.
// Ports: req_valid/req_ready/req_busy (request side), res_valid/res_ready (result side),
//        rnd_out (N-bit random word) and health_fail (repetition-count failure flag).
interface trng_vn_collector_if #(
  parameter int N = 128
);
  logic         req_valid;
  logic         req_ready;
  logic         req_busy;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] rnd_out;
  logic         health_fail;

  modport master (
    output req_valid, res_ready,
    input  req_ready, req_busy, res_valid, rnd_out, health_fail
  );

  modport slave (
    input  req_valid, res_ready,
    output req_ready, req_busy, res_valid, rnd_out, health_fail
  );
endinterface

// File: rtl/trng_vn_collector.sv
// TRNG collector: synchronises a raw entropy bit, debiases it with a von Neumann extractor
// and assembles an N-bit word delivered over the req/res handshake, with a repetition-count test.
// Ports: clk, rst (sync, active-high), raw_bit (async entropy in), bus (slave side of the handshake).
module trng_vn_collector #(
  parameter int N         = 128,
  parameter int DIV       = 4,
  parameter int RCT_LIMIT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raw_bit,
  trng_vn_collector_if.slave   bus
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(N + 1);
  localparam int RW = $clog2(RCT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t        state;
  logic          sync1, sync2;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rct_cnt;
  logic          rct_prev;
  logic          have_sample;   // RCT has a previous sample to compare against
  logic          pair_half;     // first bit of the current pair is held in pair_a
  logic          pair_a;
  logic [N-1:0]  sh;

  logic          strobe;
  logic [RW-1:0] rct_next;
  logic          rct_trip;
  logic          vn_emit;
  logic [N-1:0]  sh_next;

  assign strobe   = (state == COLLECT) && (div == DW'(DIV - 1));
  assign rct_next = (have_sample && (sync2 == rct_prev)) ? rct_cnt + RW'(1) : RW'(1);
  assign rct_trip = strobe && (rct_next == RW'(RCT_LIMIT));
  // Second half of a pair with differing bits: "10" emits 1, "01" emits 0, i.e. the first bit.
  assign vn_emit  = strobe && pair_half && (pair_a != sync2);
  assign sh_next  = {sh[N-2:0], pair_a};

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sync1           <= 1'b0;
      sync2           <= 1'b0;
      div             <= '0;
      cnt             <= '0;
      rct_cnt         <= '0;
      rct_prev        <= 1'b0;
      have_sample     <= 1'b0;
      pair_half       <= 1'b0;
      pair_a          <= 1'b0;
      sh              <= '0;
      bus.req_ready   <= 1'b0;
      bus.req_busy    <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.rnd_out     <= '0;
      bus.health_fail <= 1'b0;
    end else begin
      sync1 <= raw_bit;
      sync2 <= sync1;
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            state           <= COLLECT;
            bus.req_ready   <= 1'b0;
            bus.req_busy    <= 1'b1;
            bus.health_fail <= 1'b0;
            cnt             <= '0;
            div             <= '0;
            rct_cnt         <= '0;
            have_sample     <= 1'b0;
            pair_half       <= 1'b0;
            sh              <= '0;
          end
        end
        COLLECT: begin
          div <= (div == DW'(DIV - 1)) ? '0 : div + DW'(1);
          if (strobe) begin
            rct_prev    <= sync2;
            have_sample <= 1'b1;
            rct_cnt     <= rct_next;
            pair_half   <= ~pair_half;
            pair_a      <= sync2;
            if (rct_trip) begin
              // Health failure discards the partial word.
              state           <= DONE;
              bus.res_valid   <= 1'b1;
              bus.health_fail <= 1'b1;
              bus.rnd_out     <= '0;
            end else if (vn_emit) begin
              sh  <= sh_next;
              cnt <= cnt + CW'(1);
              if (cnt == CW'(N - 1)) begin
                state         <= DONE;
                bus.res_valid <= 1'b1;
                bus.rnd_out   <= sh_next;
              end
            end
          end
        end
        DONE: begin
          if (bus.res_valid && bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
            bus.req_busy  <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
